// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
//   Geometry and state definitions for the bordered-frame pixel interface.
//   Shared between the transmit side (frame_streamer) and the capture block,
//   so both agree on raster size, active-window placement and FSM encoding.
// -----------------------------------------------------------------------------
package frame_pkg;

  // Active image held in the buffer
  localparam int unsigned ACT_W   = 300;
  localparam int unsigned ACT_H   = 100;

  // Full raster including the border
  localparam int unsigned TOT_W   = 330;
  localparam int unsigned TOT_H   = 110;

  // Top-left corner of the active window inside the raster
  localparam int unsigned H_OFF   = 30;
  localparam int unsigned V_OFF   = 10;

  localparam int unsigned ACT_PIX = ACT_W * ACT_H;   // 30000
  localparam int unsigned TOT_PIX = TOT_W * TOT_H;   // 36300

  // Widths: buffer address and raster coordinate counters
  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned CNT_W   = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } fsm_state_t;

  // True when raster coordinate (px, ln) lies inside the active window.
  function automatic logic in_window(input logic [CNT_W-1:0] px,
                                     input logic [CNT_W-1:0] ln);
    return (px >= CNT_W'(H_OFF)) && (px < CNT_W'(H_OFF + ACT_W)) &&
           (ln >= CNT_W'(V_OFF)) && (ln < CNT_W'(V_OFF + ACT_H));
  endfunction

endpackage

// File: rtl/frame_ram.sv
// -----------------------------------------------------------------------------
// frame_ram
//   Simple dual-port image buffer: one write port, one synchronous read port
//   with read enable. Read data appears one clock after rd_en/rd_addr and is
//   held while rd_en is low, which lets the streamer freeze its output stage
//   during back-pressure without re-reading.
//
// Ports
//   clk      in   clock
//   we       in   write strobe (already qualified by the caller)
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read enable; rd_data updates only when high
//   rd_addr  in   read address
//   rd_data  out  registered read data
// -----------------------------------------------------------------------------
module frame_ram
  import frame_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned DEPTH = ACT_PIX,
  parameter int unsigned AW    = ADDR_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PIX_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/frame_streamer.sv
// -----------------------------------------------------------------------------
// frame_streamer
//   Transmit side of the bordered-frame pixel interface. Holds one 300x100
//   active image and, for each start pulse, emits the complete 330x110 raster
//   in row-major order: BORDER_VAL outside the active window, buffered pixels
//   inside it (window origin at column 30, line 10).
//
//   Two-stage pipeline:
//     p0 : raster counters + buffer address counter pick the next beat and
//          issue the synchronous buffer read.
//     p1 : output register (valid, coordinates, active flag) aligned with the
//          buffer read data; px_data is selected from these registered values.
//   Everything advances only on adv = ~px_valid | px_ready, so a stalled beat
//   keeps px_data / PxOut / LineOut frozen.
//
// Ports
//   clk, reset   clock, synchronous active-high reset (buffer not cleared)
//   wr_en/wr_addr/wr_data  image buffer write; accepted only in IDLE with
//                          wr_addr < 30000, otherwise wr_err pulses next cycle
//   start        pulse: begin one frame (ignored unless IDLE)
//   px_ready     downstream accepts the current beat
//   px_data      pixel beat
//   px_valid     beat valid
//   PxOut        column of current beat, 0..329
//   LineOut      line of current beat, 0..109
//   busy         frame in progress (STREAM or DONE)
//   frame_done   one-cycle pulse after the last beat is accepted
//   wr_err       one-cycle pulse: previous write was rejected
// -----------------------------------------------------------------------------
module frame_streamer
  import frame_pkg::*;
#(
  parameter int unsigned      PIX_W      = 8,
  parameter logic [PIX_W-1:0] BORDER_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [14:0]      wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             start,
  input  logic             px_ready,
  output logic [PIX_W-1:0] px_data,
  output logic             px_valid,
  output logic [9:0]       PxOut,
  output logic [9:0]       LineOut,
  output logic             busy,
  output logic             frame_done,
  output logic             wr_err
);

  localparam logic [CNT_W-1:0]  LAST_PX = CNT_W'(TOT_W - 1);
  localparam logic [CNT_W-1:0]  LAST_LN = CNT_W'(TOT_H - 1);
  localparam logic [ADDR_W-1:0] ACT_END = ADDR_W'(ACT_PIX);

  fsm_state_t        state_q, state_d;

  logic [CNT_W-1:0]  px_cnt_q, px_cnt_d;
  logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fetch_end_q, fetch_end_d;

  logic              vld_p1_q, vld_p1_d;
  logic              act_p1_q, act_p1_d;
  logic [CNT_W-1:0]  px_p1_q, px_p1_d;
  logic [CNT_W-1:0]  line_p1_q, line_p1_d;

  logic              wr_err_q, wr_err_d;

  logic              adv;
  logic              issue;
  logic              act_p0;
  logic              last_pos_p0;
  logic              last_acc;
  logic              wr_ok;
  logic [PIX_W-1:0]  rd_data;

  assign adv         = ~vld_p1_q | px_ready;
  // A new beat is fetched on every advance while streaming, until the final
  // raster position has been issued.
  assign issue       = (state_q == STREAM) & adv & ~fetch_end_q;
  assign act_p0      = in_window(px_cnt_q, line_cnt_q);
  assign last_pos_p0 = (px_cnt_q == LAST_PX) & (line_cnt_q == LAST_LN);
  assign last_acc    = vld_p1_q & px_ready & (px_p1_q == LAST_PX) & (line_p1_q == LAST_LN);
  // Writes are only safe when no frame is reading the buffer.
  assign wr_ok       = wr_en & (state_q == IDLE) & (wr_addr < ACT_END);
  assign wr_err_d    = wr_en & ~wr_ok;

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = STREAM;
      STREAM:  if (last_acc) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Stage p0: raster position and active-address counters
  // ---------------------------------------------------------------------------
  always_comb begin
    px_cnt_d    = px_cnt_q;
    line_cnt_d  = line_cnt_q;
    addr_d      = addr_q;
    fetch_end_d = fetch_end_q;
    if ((state_q == IDLE) && start) begin
      px_cnt_d    = '0;
      line_cnt_d  = '0;
      addr_d      = '0;
      fetch_end_d = 1'b0;
    end else if (issue) begin
      // Row-major raster order means the active address is just a running
      // count of active beats issued so far.
      if (act_p0) begin
        addr_d = addr_q + ADDR_W'(1);
      end
      if (last_pos_p0) begin
        fetch_end_d = 1'b1;
      end else if (px_cnt_q == LAST_PX) begin
        px_cnt_d   = '0;
        line_cnt_d = line_cnt_q + CNT_W'(1);
      end else begin
        px_cnt_d = px_cnt_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: output register, aligned with the buffer read data
  // ---------------------------------------------------------------------------
  always_comb begin
    vld_p1_d  = vld_p1_q;
    act_p1_d  = act_p1_q;
    px_p1_d   = px_p1_q;
    line_p1_d = line_p1_q;
    if (adv) begin
      vld_p1_d = issue;
      act_p1_d = issue & act_p0;
      if (issue) begin
        px_p1_d   = px_cnt_q;
        line_p1_d = line_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      px_cnt_q    <= '0;
      line_cnt_q  <= '0;
      addr_q      <= '0;
      fetch_end_q <= 1'b0;
      vld_p1_q    <= 1'b0;
      act_p1_q    <= 1'b0;
      px_p1_q     <= '0;
      line_p1_q   <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_cnt_q    <= px_cnt_d;
      line_cnt_q  <= line_cnt_d;
      addr_q      <= addr_d;
      fetch_end_q <= fetch_end_d;
      vld_p1_q    <= vld_p1_d;
      act_p1_q    <= act_p1_d;
      px_p1_q     <= px_p1_d;
      line_p1_q   <= line_p1_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // Read enable follows adv so the read data register freezes with the rest
  // of stage p1 during a stall.
  frame_ram #(
    .PIX_W (PIX_W),
    .DEPTH (ACT_PIX),
    .AW    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we      (wr_ok),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (adv),
    .rd_addr (addr_q),
    .rd_data (rd_data)
  );

  // The active flag masks stale read data on border beats and after reset.
  assign px_data  = act_p1_q ? rd_data : BORDER_VAL;
  assign px_valid = vld_p1_q;
  assign PxOut    = px_p1_q;
  assign LineOut  = line_p1_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_frame_streamer.sv
module tb_frame_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        start;
  logic        px_ready;
  logic [7:0]  px_data;
  logic        px_valid;
  logic [9:0]  PxOut;
  logic [9:0]  LineOut;
  logic        busy;
  logic        frame_done;
  logic        wr_err;

  always #5 clk = ~clk;

  frame_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .px_ready   (px_ready),
    .px_data    (px_data),
    .px_valid   (px_valid),
    .PxOut      (PxOut),
    .LineOut    (LineOut),
    .busy       (busy),
    .frame_done (frame_done),
    .wr_err     (wr_err)
  );

  typedef struct {
    int px;
    int ln;
    int dat;
    bit known;
  } beat_t;

  typedef struct {
    int idx;
    int px;
    int ln;
    int dat;
  } spot_t;

  // Hand-computed beats: index = line*330 + col; active data = buf[(line-10)*300 + col-30]
  spot_t spots [9] = '{
    '{0,     0,   0,   8'h00},
    '{3329,  29,  10,  8'h00},
    '{3330,  30,  10,  8'h00},
    '{3331,  31,  10,  8'h01},
    '{3335,  35,  10,  8'h05},
    '{7720,  130, 23,  8'hA0},
    '{35969, 329, 108, 8'h03},
    '{36298, 328, 109, 8'h2E},
    '{36299, 329, 109, 8'h2F}
  };

  bit [7:0] mem_m   [30000];
  bit       known_m [30000];
  beat_t    exp_q [$];
  beat_t    mb;

  int checks      = 0;
  int failures    = 0;
  int beat_idx    = 0;
  int frames_done = 0;
  bit stall_en    = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t model_beat(input int p, input int l);
    beat_t b;
    int a;
    b.px = p; b.ln = l; b.dat = 0; b.known = 1'b1;
    if (p >= 30 && p < 330 && l >= 10 && l < 110) begin
      a = (l - 10) * 300 + (p - 30);
      b.dat   = int'(mem_m[a]);
      b.known = known_m[a];
    end
    return b;
  endfunction

  // ------------------------------------------------------------------ monitor
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic [9:0] prev_px, prev_ln;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      beat_idx   = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(px_valid), 1);
        check("stall_hold", {px_data, PxOut, LineOut}, {prev_data, prev_px, prev_ln});
      end
      if (frame_done) begin
        frames_done++;
        check("frame_beats", beat_idx, 36300);
        beat_idx = 0;
      end
      if (px_valid && px_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", beat_idx, -1);
        end else begin
          mb = exp_q.pop_front();
          check("beat_px", int'(PxOut), mb.px);
          check("beat_line", int'(LineOut), mb.ln);
          if (mb.known) check("beat_data", int'(px_data), mb.dat);
        end
        foreach (spots[k]) begin
          if (spots[k].idx == beat_idx) begin
            check("spot_px", int'(PxOut), spots[k].px);
            check("spot_line", int'(LineOut), spots[k].ln);
            check("spot_data", int'(px_data), spots[k].dat);
          end
        end
        beat_idx++;
      end
      prev_stall = px_valid && !px_ready;
      prev_data  = px_data;
      prev_px    = PxOut;
      prev_ln    = LineOut;
    end
  end

  // --------------------------------------------------------- ready generator
  initial begin
    px_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      px_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic write_px(input int a, input int d, input bit ok);
    wr_en   = 1'b1;
    wr_addr = 15'(a);
    wr_data = 8'(d);
    if (ok) begin
      mem_m[a]   = 8'(d);
      known_m[a] = 1'b1;
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic start_frame(input bit with_wr);
    if (with_wr) begin
      wr_en   = 1'b1;
      wr_addr = 15'd4000;
      wr_data = 8'hA0;
      mem_m[4000]   = 8'hA0;
      known_m[4000] = 1'b1;
    end
    for (int l = 0; l < 110; l++)
      for (int p = 0; p < 330; p++)
        exp_q.push_back(model_beat(p, l));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_en = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("valid_lat1", int'(px_valid), 0);
    @(posedge clk);
    #1;
    check("valid_lat2", int'(px_valid), 1);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c;
    c = 0;
    while (beat_idx < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (beat_idx < n) check("timeout_beats", beat_idx, n);
  endtask

  task automatic wait_done(input int target, input int budget);
    int c;
    c = 0;
    while (frames_done < target && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (frames_done < target) check("timeout_done", frames_done, target);
  endtask

  initial begin
    int d0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_px_valid", int'(px_valid), 0);
    check("rst_px_data", int'(px_data), 0);
    check("rst_PxOut", int'(PxOut), 0);
    check("rst_LineOut", int'(LineOut), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_wr_err", int'(wr_err), 0);
    reset = 1'b0;

    // Load buf[i] = i[7:0] over the regions the frame checks rely on
    for (int i = 0; i < 4000; i++) write_px(i, i & 255, 1'b1);
    for (int i = 29400; i < 30000; i++) write_px(i, i & 255, 1'b1);
    check("wr_err_good_write", int'(wr_err), 0);

    // Frame A: write lands with start, random back-pressure early in frame
    stall_en = 1'b1;
    start_frame(1'b1);
    wait_beats(5000, 20000);
    stall_en = 1'b0;
    wait_done(1, 60000);
    @(posedge clk);
    #1;
    check("busy_after_done", int'(busy), 0);
    check("valid_after_done", int'(px_valid), 0);
    check("queue_empty_A", exp_q.size(), 0);
    check("frames_A", frames_done, 1);

    // Out-of-range write in IDLE is rejected with a one-cycle pulse
    write_px(30000, 8'h11, 1'b0);
    check("wr_err_range", int'(wr_err), 1);
    @(posedge clk);
    #1;
    check("wr_err_pulse_end", int'(wr_err), 0);

    // Frame aborted by reset at beat 1000
    start_frame(1'b0);
    wait_beats(1000, 5000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_valid", int'(px_valid), 0);
    check("abort_busy", int'(busy), 0);
    exp_q.delete();
    d0 = frames_done;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", frames_done, d0);

    // Frame B: original data, ignored starts, write while streaming
    start_frame(1'b0);
    wait_beats(10, 1000);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_beats(2000, 5000);
    write_px(5, 8'hAA, 1'b0);
    check("wr_err_busy", int'(wr_err), 1);
    wait_beats(36299, 40000);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(d0 + 1, 1000);
    repeat (6) @(posedge clk);
    #1;
    check("single_frame_done", frames_done, d0 + 1);
    check("no_second_frame", int'(px_valid), 0);
    check("idle_busy", int'(busy), 0);
    check("queue_empty_B", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
